// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver family: parity encodings,
// FSM state encoding and divider constants for a 12 MHz system clock.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // S_BREAK and S_MAB are only reachable when UART_TX_BREAK_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_MAB
  } uart_state_e;

  localparam int BAUD_DIV_115200 = 104;
  localparam int BAUD_DIV_57600  = 208;
  localparam int BAUD_DIV_38400  = 312;
  localparam int BAUD_DIV_19200  = 625;
  localparam int BAUD_DIV_9600   = 1250;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period divider with synchronous clear; tick marks the last
// clk cycle of each BAUD_DIV-cycle period.
module uart_baud_tick #(
  parameter int BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: BAUD_DIV must be >= 2");
  end

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one character per start/ready handshake.
// Optional break generation (send_break port) is enabled with UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = BAUD_DIV_115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx,
  output logic                 ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 accept;
  logic                 baud_en;
  logic                 baud_clear;

`ifdef UART_TX_BREAK_EN
  assign ready      = (state_q == S_IDLE) && !send_break;
  assign baud_clear = accept || ((state_q == S_BREAK) && !send_break);
`else
  assign ready      = (state_q == S_IDLE);
  assign baud_clear = accept;
`endif

  assign accept  = start && ready;
  assign busy    = !ready && !rst;
  assign baud_en = (state_q != S_IDLE) && (state_q != S_BREAK);
  assign tx      = tx_q;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .en   (baud_en),
    .tick (tick)
  );

  // Parity accumulates from bits leaving the captured shift register, so the
  // live data bus is never looked at after the accept cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = data;
          par_d   = 1'b0;
        end
`ifdef UART_TX_BREAK_EN
        else if (send_break) begin
          state_d = S_BREAK;
        end
`endif
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (bit_cnt_q == DATA_LAST) begin
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!send_break) state_d = S_MAB;
      end
      S_MAB: begin
        if (tick) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) bit_cnt_d = '0;
  end

  // tx is derived from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d ^ (PARITY == PAR_ODD);
      S_BREAK:  tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised successor to the fixed 8N1 low-level UART transmitter. Serialises one character per valid/ready handshake with compile-time data width, parity mode and stop-bit count, and reports frame completion. Has its own baud divider, so no external baud generator is needed. Sits between a byte source (FIFO, CPU bridge, test pattern generator) and the board TX pin.

Parameters:
DATA_BITS, 8, character width, legal 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal (elaboration error).
STOP_BITS, 1, 1 or 2 stop bits.
BAUD_DIV, 104, clk cycles per bit (12 MHz / 115200); legal >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous to clk, active-high.
start  in  1  request; data is accepted on a cycle where start && ready.
data  in  DATA_BITS  character, sampled on the accept cycle only.
tx  out  1  serial line; idles high.
ready  out  1  high when idle and able to accept.
busy  out  1  high from the cycle after accept until the frame ends.
done  out  1  one-cycle pulse on the final clk cycle of the last stop bit.

Behaviour:
- Reset (rst=1 at posedge) gives: tx=1, ready=1, busy=0, done=0, state IDLE, all counters 0.
- Reset has priority over every other event. Reset mid-frame aborts the frame: tx=1 on the next cycle and no done pulse.
- FSM states and transitions:
  - IDLE: on accept go to START.
  - START: one bit period, tx=0.
  - DATA: DATA_BITS periods, LSB first.
  - PARITY: one period; skipped when PARITY=0.
  - STOP: STOP_BITS periods, tx=1.
  - From STOP go back to IDLE.
- Latency: accept at cycle N gives tx=0 from cycle N+1. Every bit period is exactly BAUD_DIV cycles.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- ready is combinational from the state: 1 only in IDLE. busy equals !ready except during reset.
- Back-to-back: ready rises in the cycle after done. An accept in that same cycle starts the next START bit, giving zero idle gap beyond 1 cycle.
- start while busy is ignored, and data is not captured.
- Parity bit: even = XOR of the data bits; odd = its inverse. It is computed from the captured data register, not from the live input.
- Baud counter: width $clog2(BAUD_DIV). Cleared on accept. A tick is generated when count == BAUD_DIV-1, then the counter wraps to 0.
- Bit counter: 4 bits, cleared on every state change, incremented on tick.
- tx is registered and glitch-free. The shift register loads {data} on accept and shifts right on each DATA tick.
- done pulses exactly once per completed frame.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input send_break (1 bit).
  - While in IDLE with send_break=1, tx=0 and ready=0. start is not accepted.
  - When send_break drops, tx=1 next cycle and ready returns after one full bit period (mark-after-break).
  - send_break asserted mid-frame takes effect only after done.
- Undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state localparams S_IDLE..S_STOP;
  - the default BAUD_DIV constants for 12 MHz (115200, 57600, 38400, 19200, 9600).
- One sub-module, uart_baud_tick:
  - parameters BAUD_DIV;
  - ports clk, rst, clear, en, tick;
  - free-running divider with synchronous clear, reused later by the RX successor.

Test Plan:
- BAUD_DIV=4, 8N1, accept data=0x55 at cycle 10 -> tx=0 cycles 11-14, then bits 1,0,1,0,1,0,1,0 in 4-cycle periods, stop high 47-50, done=1 at cycle 50, ready=1 at 51.
- 8E1, data=0x07 -> parity bit 1. 8O1, data=0x07 -> parity bit 0. Frame length 44 cycles with BAUD_DIV=4.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, data=0x41 -> 11 bits, bits sent 1,0,0,0,0,0,1, parity 1, two high stop periods. Bit 7 of the driving bus is ignored.
- Back-to-back 0xA5 then 0x3C with start held -> second start bit begins 1 cycle after first done. Exactly 2 done pulses; decoded bytes match.
- start pulsed with 0xFF mid-frame of 0x00 -> ignored; only 0x00 is transmitted.
- rst asserted in DATA of 0x81 -> tx=1, ready=1 next cycle, no done. Then 0x81 re-sent correctly.
- With UART_TX_BREAK_EN: send_break held 20 cycles -> tx=0 throughout, ready=0. After release, tx=1 and ready=1 after BAUD_DIV cycles.
